prog_loader: RTL and testbench



---
 rtl/prog_loader_pkg.sv | 26 ++
 rtl/prog_loader_ldr_chk.sv | 40 ++++
 rtl/prog_loader.sv | 161 ++++++++++++++++
 tb/tb_prog_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants and checksum step functions for the MCX program loader.
// LOADER_CRC8_EN selects the CRC-8 checksum instead of the byte XOR.
package prog_loader_pkg;

    localparam int          LINES   = 16;
    localparam int          LINE_W  = 46;
    localparam int          ADDR_W  = 4;
    localparam int          CNT_W   = 5;
    localparam logic [7:0]  HDR     = 8'hA5;
    localparam logic [7:0]  LINES_B = 8'd16;

    function automatic logic [7:0] chk_xor_step(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    // CRC-8, poly 0x07, MSB first
    function automatic logic [7:0] chk_crc8_step(input logic [7:0] acc, input logic [7:0] data);
        logic [7:0] c;
        c = acc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/prog_loader_ldr_chk.sv
// Byte-wide frame checksum accumulator: XOR by default, CRC-8 under LOADER_CRC8_EN.
module ldr_chk
    import prog_loader_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] chk
);

    logic [7:0] r_acc;
    logic [7:0] w_next;

    // One accumulation step for the configured checksum
    always_comb begin
`ifdef LOADER_CRC8_EN
        w_next = chk_crc8_step(r_acc, data);
`else
        w_next = chk_xor_step(r_acc, data);
`endif
    end

    // Accumulator register; clear wins over enable
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_acc <= 8'h00;
        end else if (clr) begin
            r_acc <= 8'h00;
        end else if (en) begin
            r_acc <= w_next;
        end else begin
            r_acc <= r_acc;
        end
    end

    assign chk = r_acc;

endmodule

// File: rtl/prog_loader.sv
// MCX program loader: byte frames (HDR, N, N x 6 line bytes, CHK) into prog_mem lines.
// Core is held in reset from HDR until the checksum verifies; LOADER_CRC8_EN picks CRC-8.
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [LINE_W-1:0] wr_line,
    output logic              core_nrst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHECK = 3'd4,
        ST_ERR   = 3'd5
    } ldr_state_e;

    ldr_state_e        r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_byte_idx;
    logic [47:0]       r_shreg;
    logic              r_wr_en, r_busy, r_done, r_err, r_run_q;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [LINE_W-1:0] r_wr_line;
    logic              w_ready, w_accept, w_chk_clr, w_chk_en, w_last, w_bad_n, w_bad_b0;
    logic [7:0]        w_chk;

    ldr_chk u_chk (
        .clk  (clk),
        .nrst (nrst),
        .clr  (w_chk_clr),
        .en   (w_chk_en),
        .data (in_data),
        .chk  (w_chk)
    );

    // Next-state and handshake decode
    always_comb begin
        w_next    = r_state;
        w_ready   = (r_state != ST_WRITE);
        w_accept  = in_valid & w_ready;
        w_chk_clr = (r_state == ST_COUNT) & w_accept;
        w_chk_en  = (r_state == ST_DATA) & w_accept;
        w_last    = ({1'b0, r_wr_addr} == (r_cnt - 5'd1));
        w_bad_n   = (in_data == 8'd0) || (in_data > LINES_B);
        w_bad_b0  = (r_byte_idx == 3'd0) && (in_data[7:6] != 2'b00);
        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (w_accept && (in_data == HDR)) w_next = ST_COUNT;
                else                              w_next = r_state;
            end
            ST_COUNT: begin
                if (w_accept) w_next = w_bad_n ? ST_ERR : ST_DATA;
                else          w_next = ST_COUNT;
            end
            ST_DATA: begin
                if (!w_accept)                w_next = ST_DATA;
                else if (w_bad_b0)            w_next = ST_ERR;
                else if (r_byte_idx == 3'd5)  w_next = ST_WRITE;
                else                          w_next = ST_DATA;
            end
            ST_WRITE: begin
                if (w_last) w_next = ST_CHECK;
                else        w_next = ST_DATA;
            end
            ST_CHECK: begin
                if (w_accept) w_next = (in_data == w_chk) ? ST_IDLE : ST_ERR;
                else          w_next = ST_CHECK;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Datapath, status flags and core-run control
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt      <= 5'd0;
            r_byte_idx <= 3'd0;
            r_shreg    <= 48'd0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= 4'd0;
            r_wr_line  <= 46'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_run_q    <= 1'b1;
        end else begin
            r_wr_en <= (w_next == ST_WRITE);
            r_busy  <= (w_next == ST_COUNT) || (w_next == ST_DATA) ||
                       (w_next == ST_WRITE) || (w_next == ST_CHECK);
            if ((w_next == ST_ERR) && (r_state != ST_ERR)) r_err <= 1'b1;
            case (r_state)
                ST_IDLE, ST_ERR: begin
                    if (w_accept && (in_data == HDR)) begin
                        r_run_q <= 1'b0;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (w_accept && !w_bad_n) begin
                        r_cnt      <= in_data[CNT_W-1:0];
                        r_wr_addr  <= 4'd0;
                        r_byte_idx <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_shreg <= {r_shreg[39:0], in_data};
                        if (r_byte_idx == 3'd5) begin
                            r_byte_idx <= 3'd0;
                            r_wr_line  <= {r_shreg[37:0], in_data};
                        end else begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    // Hold the last address rather than wrapping past LINES-1
                    if (!w_last) r_wr_addr <= r_wr_addr + 4'd1;
                end
                ST_CHECK: begin
                    if (w_accept && (in_data == w_chk)) begin
                        r_done  <= 1'b1;
                        r_run_q <= 1'b1;
                    end
                end
                default: begin
                    r_run_q <= r_run_q;
                end
            endcase
        end
    end

    assign in_ready  = w_ready;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_line   = r_wr_line;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign core_nrst = nrst & r_run_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed plus randomized bench for prog_loader against a frame-level reference model.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic        clk = 1'b0;
    logic        nrst, in_valid, in_ready, wr_en, core_nrst, busy, done, err;
    logic [7:0]  in_data;
    logic [3:0]  wr_addr;
    logic [45:0] wr_line;

    int n_vec  = 0;
    int n_fail = 0;
    int n_ready_low = 0;

    logic [3:0]  wq_addr[$];
    logic [45:0] wq_line[$];
    logic [7:0]  frame_q[$];
    logic [45:0] exp_lines[$];

    prog_loader dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_line(wr_line),
        .core_nrst(core_nrst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            wq_addr.push_back(wr_addr);
            wq_line.push_back(wr_line);
        end
        if (!in_ready) n_ready_low++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference checksum over the line bytes of exp_lines
    function automatic logic [7:0] model_chk();
        logic [7:0]  c = 8'h00;
        logic [47:0] w;
        foreach (exp_lines[i]) begin
            w = {2'b00, exp_lines[i]};
            for (int b = 5; b >= 0; b--) begin
`ifdef LOADER_CRC8_EN
                c = c ^ w[b*8 +: 8];
                for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
`else
                c = c ^ w[b*8 +: 8];
`endif
            end
        end
        return c;
    endfunction

    // Frame bytes (HDR, N, lines) from exp_lines; caller appends CHK
    task automatic build_frame();
        logic [47:0] w;
        frame_q.delete();
        frame_q.push_back(HDR);
        frame_q.push_back(8'(exp_lines.size()));
        foreach (exp_lines[i]) begin
            w = {2'b00, exp_lines[i]};
            for (int b = 5; b >= 0; b--) frame_q.push_back(w[b*8 +: 8]);
        end
    endtask

    task automatic random_lines(input int n);
        logic [63:0] r;
        exp_lines.delete();
        for (int i = 0; i < n; i++) begin
            r = {$urandom(), $urandom()};
            exp_lines.push_back(r[45:0]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("send_handshake", 64'(got), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame();
        foreach (frame_q[i]) send_byte(frame_q[i]);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, 64'(wq_addr.size()), 64'(exp_lines.size()));
        for (int i = 0; i < wq_addr.size() && i < exp_lines.size(); i++) begin
            check({tag, "_addr"}, 64'(wq_addr[i]), 64'(i));
            check({tag, "_line"}, 64'(wq_line[i]), 64'(exp_lines[i]));
        end
        wq_addr.delete();
        wq_line.delete();
    endtask

    task automatic check_status(input string tag, input bit d, input bit e, input bit c);
        check({tag, "_done"}, 64'(done), 64'(d));
        check({tag, "_err"}, 64'(err), 64'(e));
        check({tag, "_core_nrst"}, 64'(core_nrst), 64'(c));
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [7:0] c;
        bit bad;
        int n;
        nrst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #12;
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_line", 64'(wr_line), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check_status("rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        check("rst_core_runs", 64'(core_nrst), 64'd1);

        // 1: single-line frame with known checksum
        exp_lines = '{46'h2A};
        send_byte(HDR);
        check("t1_core_held", 64'(core_nrst), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        send_byte(8'h01);
        for (int i = 0; i < 5; i++) send_byte(8'h00);
        send_byte(8'h2A);
        check("t1_wr_en", 64'(wr_en), 64'd1);
        check("t1_wr_addr", 64'(wr_addr), 64'd0);
        check("t1_wr_line", 64'(wr_line), 64'h2A);
        check("t1_core_still_held", 64'(core_nrst), 64'd0);
`ifdef LOADER_CRC8_EN
        send_byte(8'hD6);
`else
        send_byte(8'h2A);
`endif
        in_valid = 1'b0;
        check_status("t1", 1'b1, 1'b0, 1'b1);
        check_writes("t1");

        // 2: bad line counts
        frame_q = '{HDR, 8'h11};
        send_frame();
        check_status("t2a", 1'b0, 1'b1, 1'b0);
        frame_q = '{HDR, 8'h00};
        send_byte(HDR);
        check("t2_err_cleared", 64'(err), 64'd0);
        send_byte(8'h00);
        in_valid = 1'b0;
        check_status("t2b", 1'b0, 1'b1, 1'b0);
        exp_lines.delete();
        check_writes("t2");

        // 3: nonzero top bits in the first line byte
        send_byte(HDR); send_byte(8'h01); send_byte(8'hC0);
        check("t3_err_now", 64'(err), 64'd1);
        for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i));
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_status("t3", 1'b0, 1'b1, 1'b0);
        check_writes("t3");

        // 4: wrong checksum, then a good frame
        random_lines(1);
        build_frame();
        frame_q.push_back(model_chk() ^ 8'hFF);
        send_frame();
        check_status("t4a", 1'b0, 1'b1, 1'b0);
        check_writes("t4a");
        random_lines(2);
        build_frame();
        frame_q.push_back(model_chk());
        send_frame();
        check_status("t4b", 1'b1, 1'b0, 1'b1);
        check_writes("t4b");

        // 5: reset mid-frame
        random_lines(1);
        build_frame();
        for (int i = 0; i < 5; i++) send_byte(frame_q[i]);
        nrst = 1'b0;
        #1;
        check("t5_wr_en", 64'(wr_en), 64'd0);
        check("t5_wr_addr", 64'(wr_addr), 64'd0);
        check("t5_wr_line", 64'(wr_line), 64'd0);
        check_status("t5_rst", 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #20;
        nrst = 1'b1;
        #1;
        check("t5_core_follows", 64'(core_nrst), 64'd1);
        exp_lines.delete();
        check_writes("t5_none");
        random_lines(3);
        build_frame();
        frame_q.push_back(model_chk());
        send_frame();
        check_status("t5_after", 1'b1, 1'b0, 1'b1);
        check_writes("t5_after");

        // 6: full 16-line image, valid held high
        random_lines(16);
        build_frame();
        frame_q.push_back(model_chk());
        n_ready_low = 0;
        send_frame();
        check("t6_ready_low", 64'(n_ready_low), 64'd16);
        check_status("t6", 1'b1, 1'b0, 1'b1);
        check_writes("t6");

        // Randomized frames, some with a corrupted checksum
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, 16);
            bad = ($urandom_range(0, 3) == 0);
            random_lines(n);
            build_frame();
            c = model_chk();
            frame_q.push_back(bad ? (c ^ 8'(1 << $urandom_range(0, 7))) : c);
            send_frame();
            check_status("rand", !bad, bad, !bad);
            check_writes("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
